// File: rtl/aes_if_pkg.sv
// aes_if_pkg: shared definitions for the Avalon AES register front end.
// Address map constants, status bit indices, FSM state type, byte merge.
package aes_if_pkg;

  localparam logic [3:0] ADDR_KEY0   = 4'd0;
  localparam logic [3:0] ADDR_MSG0   = 4'd4;
  localparam logic [3:0] ADDR_DEC0   = 4'd8;
  localparam logic [3:0] ADDR_CTRL   = 4'd14;
  localparam logic [3:0] ADDR_STATUS = 4'd15;

  localparam int ST_DONE    = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_TIMEOUT = 2;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    CAPTURE
  } aes_if_state_t;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/aes_if_regfile.sv
// aes_if_regfile: RW key/msg words 0-7, hardware-loaded plaintext 8-11,
// registered read mux (ctrl/status folded in). Ports: bus, capture, views.
module aes_if_regfile
  import aes_if_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we_i,
  input  logic         re_i,
  input  logic [3:0]   addr_i,
  input  logic [3:0]   be_i,
  input  logic [31:0]  wdata_i,
  input  logic         cap_i,
  input  logic [127:0] cap_data_i,
  input  logic         busy_i,
  input  logic         done_i,
  input  logic         timeout_i,
  output logic [31:0]  rdata_o,
  output logic [127:0] key_o,
  output logic [127:0] msg_o,
  output logic [31:0]  export_o
);

  logic [31:0] rw_q [8];
  logic [31:0] dec_q [4];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = '0;
      unique case (1'b1)
        !addr_i[3]:             rdata_d = rw_q[addr_i[2:0]];
        addr_i[3:2] == 2'b10:   rdata_d = dec_q[addr_i[1:0]];
        addr_i == ADDR_CTRL:    rdata_d[0] = busy_i;
        addr_i == ADDR_STATUS: begin
          rdata_d[ST_DONE]    = done_i;
          rdata_d[ST_BUSY]    = busy_i;
          rdata_d[ST_TIMEOUT] = timeout_i;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) rw_q[i] <= '0;
      for (int i = 0; i < 4; i++) dec_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i && !addr_i[3])
        rw_q[addr_i[2:0]] <= be_merge(rw_q[addr_i[2:0]], wdata_i, be_i);
      if (cap_i) begin
        dec_q[0] <= cap_data_i[127:96];
        dec_q[1] <= cap_data_i[95:64];
        dec_q[2] <= cap_data_i[63:32];
        dec_q[3] <= cap_data_i[31:0];
      end
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign key_o    = {rw_q[0], rw_q[1], rw_q[2], rw_q[3]};
  assign msg_o    = {rw_q[4], rw_q[5], rw_q[6], rw_q[7]};
  assign export_o = {rw_q[0][31:16], rw_q[3][15:0]};

endmodule

// File: rtl/avalon_aes_interface.sv
// avalon_aes_interface: Avalon-MM slave front end for the AES decrypt core.
// Bus regs + launch/busy/capture FSM with watchdog; drives core and hex export.
module avalon_aes_interface
  import aes_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TCNT_W         = 13
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC,
  output logic [31:0]  EXPORT_DATA
);

  localparam logic [TCNT_W-1:0] WD_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TCNT_W-1:0] WD_ONE  = TCNT_W'(1);

  aes_if_state_t     state_q, state_d;
  logic [TCNT_W-1:0] wd_q, wd_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              cap;
  logic              busy;
  logic              bus_wr;
  logic              ctrl_wr;
  logic              stat_wr;
  logic              abort;

  assign busy    = (state_q != IDLE);
  assign bus_wr  = AVL_CS & AVL_WRITE;
  assign ctrl_wr = bus_wr && AVL_ADDR == ADDR_CTRL && AVL_BYTE_EN[0];
  assign stat_wr = bus_wr && AVL_ADDR == ADDR_STATUS && AVL_BYTE_EN[0];
  assign abort   = busy && ctrl_wr && !AVL_WRITEDATA[0];

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    cap     = 1'b0;
    // W1C first so that a same-cycle hardware set overrides it
    if (stat_wr) begin
      if (AVL_WRITEDATA[ST_DONE])    done_d = 1'b0;
      if (AVL_WRITEDATA[ST_TIMEOUT]) tmo_d  = 1'b0;
    end
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ctrl_wr && AVL_WRITEDATA[0]) begin
            done_d  = 1'b0;
            tmo_d   = 1'b0;
            state_d = LAUNCH;
          end
        end
        LAUNCH: begin
          wd_d    = '0;
          state_d = BUSY;
        end
        BUSY: begin
          wd_d = wd_q + WD_ONE;
          if (AES_DONE) begin
            state_d = CAPTURE;
          end else if (wd_q == WD_LAST) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
          end
        end
        CAPTURE: begin
          cap     = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      wd_q    <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  // decoded from state so an async reset drops it at once
  assign AES_START = (state_q == LAUNCH) || (state_q == BUSY);

  aes_if_regfile u_regs (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .we_i       (bus_wr && !busy),
    .re_i       (AVL_CS & AVL_READ),
    .addr_i     (AVL_ADDR),
    .be_i       (AVL_BYTE_EN),
    .wdata_i    (AVL_WRITEDATA),
    .cap_i      (cap),
    .cap_data_i (AES_MSG_DEC),
    .busy_i     (busy),
    .done_i     (done_q),
    .timeout_i  (tmo_q),
    .rdata_o    (AVL_READDATA),
    .key_o      (AES_KEY),
    .msg_o      (AES_MSG_ENC),
    .export_o   (EXPORT_DATA)
  );

endmodule

// File: tb/tb_avalon_aes_interface.sv
// tb_avalon_aes_interface: bench for the AES front end with a core stub.
// Reads go through a scoreboard queue compared one cycle after issue.
module tb_avalon_aes_interface;
  import aes_if_pkg::*;

  localparam int TMO = 16;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         AVL_CS = 1'b0;
  logic         AVL_READ = 1'b0;
  logic         AVL_WRITE = 1'b0;
  logic [3:0]   AVL_ADDR = '0;
  logic [3:0]   AVL_BYTE_EN = '0;
  logic [31:0]  AVL_WRITEDATA = '0;
  logic [31:0]  AVL_READDATA;
  logic         AES_START;
  logic         AES_DONE;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic [127:0] AES_MSG_DEC;
  logic [31:0]  EXPORT_DATA;

  logic         stub_en = 1'b0;
  logic [3:0]   stub_cnt;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 CLK = ~CLK;

  avalon_aes_interface #(
    .TIMEOUT_CYCLES (TMO),
    .TCNT_W         (5)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .AES_START     (AES_START),
    .AES_DONE      (AES_DONE),
    .AES_KEY       (AES_KEY),
    .AES_MSG_ENC   (AES_MSG_ENC),
    .AES_MSG_DEC   (AES_MSG_DEC),
    .EXPORT_DATA   (EXPORT_DATA)
  );

  // core stub: done after 5 cycles of start, held while start stays high
  always @(posedge CLK or posedge RESET) begin
    if (RESET) stub_cnt <= '0;
    else if (!AES_START) stub_cnt <= '0;
    else if (stub_cnt != 4'hf) stub_cnt <= stub_cnt + 4'd1;
  end
  assign AES_DONE    = stub_en && AES_START && stub_cnt >= 4'd5;
  assign AES_MSG_DEC = 128'h00112233445566778899aabbccddeeff;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1;
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = '0;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [31:0] e,
                        input string tag);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  // read data is valid just after the edge that sampled the read
  always @(posedge CLK) begin
    if (AVL_CS && AVL_READ && !RESET) begin
      logic [31:0] e;
      string t;
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_underrun", 1, 0);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, AVL_READDATA, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    logic [31:0] key [4];
    logic [31:0] msg [4];
    key = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    msg = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_start", AES_START, 0);
    chk("rst_rdata", AVL_READDATA, 0);
    chk("rst_key", AES_KEY, 0);
    chk("rst_export", EXPORT_DATA, 0);
    @(negedge CLK);
    RESET = 1'b0;
    bus_rd(ADDR_STATUS, 32'h0, "rst_status");

    // FIPS-197 vector through the stub
    stub_en = 1'b1;
    for (int i = 0; i < 4; i++) bus_wr(ADDR_KEY0 + 4'(i), key[i], 4'hf);
    for (int i = 0; i < 4; i++) bus_wr(ADDR_MSG0 + 4'(i), msg[i], 4'hf);
    bus_rd(4'd0, 32'h00010203, "key0_rb");
    bus_rd(4'd7, 32'h70b4c55a, "msg3_rb");
    chk("aes_key", AES_KEY, 128'h000102030405060708090a0b0c0d0e0f);
    chk("aes_msg", AES_MSG_ENC, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    bus_wr(ADDR_CTRL, 32'h1, 4'hf);
    chk("launch_start", AES_START, 1);
    k = 0;
    while (!AES_DONE && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("done_seen", AES_DONE, 1);
    // next edge enters CAPTURE; this read is sampled during it
    bus_rd(ADDR_STATUS, 32'h2, "cap_status");
    bus_rd(ADDR_STATUS, 32'h1, "post_status");
    bus_rd(ADDR_DEC0 + 4'd0, 32'h00112233, "dec0");
    bus_rd(ADDR_DEC0 + 4'd1, 32'h44556677, "dec1");
    bus_rd(ADDR_DEC0 + 4'd2, 32'h8899aabb, "dec2");
    bus_rd(ADDR_DEC0 + 4'd3, 32'hccddeeff, "dec3");
    chk("idle_start", AES_START, 0);
    bus_rd(4'd12, 32'h0, "rsvd12");
    bus_wr(ADDR_STATUS, 32'h1, 4'hf);
    bus_rd(ADDR_STATUS, 32'h0, "w1c_done");

    // byte enables
    stub_en = 1'b0;
    bus_wr(4'd0, 32'h0, 4'hf);
    bus_wr(4'd0, 32'haabbccdd, 4'b0101);
    bus_rd(4'd0, 32'h00bb00dd, "be_merge");
    chk("export", EXPORT_DATA, 32'h00bb0e0f);
    bus_wr(4'd0, 32'hffffffff, 4'h0);
    bus_rd(4'd0, 32'h00bb00dd, "be_zero");

    // busy lockout then abort
    bus_wr(ADDR_CTRL, 32'h1, 4'hf);
    bus_wr(4'd0, 32'hffffffff, 4'hf);
    bus_rd(4'd0, 32'h00bb00dd, "busy_lock");
    bus_rd(ADDR_STATUS, 32'h2, "busy_status");
    bus_rd(ADDR_CTRL, 32'h1, "busy_ctrl");
    chk("busy_start", AES_START, 1);
    bus_wr(ADDR_CTRL, 32'h0, 4'hf);
    chk("abort_start", AES_START, 0);
    bus_rd(ADDR_STATUS, 32'h0, "abort_status");
    bus_rd(ADDR_DEC0, 32'h00112233, "abort_dec");

    // watchdog timeout
    bus_wr(ADDR_CTRL, 32'h1, 4'hf);
    k = 0;
    do begin
      @(posedge CLK);
      #1;
      k++;
    end while (AES_START && k < 40);
    chk("tmo_cycles", k, 17);
    bus_rd(ADDR_STATUS, 32'h4, "tmo_status");
    bus_wr(ADDR_STATUS, 32'h4, 4'hf);
    bus_rd(ADDR_STATUS, 32'h0, "tmo_clear");

    // async reset mid-run
    bus_rd(4'd7, 32'h70b4c55a, "pre_rst");
    bus_wr(ADDR_CTRL, 32'h1, 4'hf);
    repeat (3) @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_start", AES_START, 0);
    chk("arst_rdata", AVL_READDATA, 0);
    chk("arst_key", AES_KEY, 0);
    @(negedge CLK);
    RESET = 1'b0;
    bus_rd(4'd0, 32'h0, "arst_r0");
    bus_rd(4'd7, 32'h0, "arst_r7");
    bus_rd(ADDR_DEC0, 32'h0, "arst_dec");
    bus_rd(ADDR_STATUS, 32'h0, "arst_status");

    repeat (3) @(posedge CLK);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/avalon_aes_interface.md
Name: avalon_aes_interface

Overview:
Avalon-MM slave register front end directly upstream of the AES decryption core. Software writes the key and ciphertext, then starts a decryption. The block drives the core's start/key/message inputs, waits for the core's done signal, captures the plaintext into read-only registers and reports status. It is the only path between the bus and the core, and it also drives the hex-display export word.

Parameters:
TIMEOUT_CYCLES, 4096, busy cycles without core done before the run aborts with the TIMEOUT flag set
TCNT_W, 13, width of the watchdog counter; must satisfy 2^TCNT_W > TIMEOUT_CYCLES

Ports:
CLK  in  1  single clock
RESET  in  1  asynchronous, active-high reset
AVL_CS  in  1  chip select; reads and writes are ignored when low
AVL_READ  in  1  read strobe
AVL_WRITE  in  1  write strobe
AVL_ADDR  in  4  word address 0..15
AVL_BYTE_EN  in  4  write byte enables; bit i enables data bits [8i+7:8i]
AVL_WRITEDATA  in  32  write data
AVL_READDATA  out  32  read data, registered
AES_START  out  1  level request to the core
AES_DONE  in  1  core finished; held while AES_START stays high
AES_KEY  out  128  {reg0,reg1,reg2,reg3}
AES_MSG_ENC  out  128  {reg4,reg5,reg6,reg7}
AES_MSG_DEC  in  128  core plaintext output
EXPORT_DATA  out  32  {reg0[31:16], reg3[15:0]}, for the hex display

Behaviour:
- Register map:
  - 0-3 KEY, RW; reg0 holds the MSW.
  - 4-7 MSG_ENC, RW.
  - 8-11 MSG_DEC, read-only; loaded by hardware only.
  - 12-13 reserved; reads return 0, writes are ignored.
  - 14 CTRL: bit0 START, write 1 to launch; reads return the BUSY state.
  - 15 STATUS: bit0 DONE (write 1 to clear), bit1 BUSY (read-only), bit2 TIMEOUT (write 1 to clear); other bits read 0.
- Reset (async): all registers 0, AES_START=0, AVL_READDATA=0, FSM=IDLE, watchdog=0.
- Reads: when AVL_CS&AVL_READ are high at edge N, AVL_READDATA holds the addressed word after edge N (1-cycle latency). Otherwise AVL_READDATA holds its previous value.
- Writes: when AVL_CS&AVL_WRITE are high, byte-enabled merge into regs 0-7. A write with AVL_BYTE_EN=0 changes nothing.
- FSM states: IDLE, LAUNCH, BUSY, CAPTURE.
  - IDLE: a CTRL write with bit0=1 and BYTE_EN[0]=1 clears DONE and TIMEOUT, then goes to LAUNCH.
  - LAUNCH: 1 cycle; AES_START=1; watchdog cleared; go to BUSY. The extra cycle lets the core sample stable key/msg.
  - BUSY: AES_START=1; watchdog increments each cycle.
    - AES_DONE=1: go to CAPTURE.
    - Else if watchdog==TIMEOUT_CYCLES-1: set TIMEOUT, AES_START=0, go to IDLE.
  - CAPTURE: 1 cycle; regs 8-11 <= AES_MSG_DEC; DONE=1; AES_START=0; go to IDLE.
- BUSY bit = (state != IDLE).
- While BUSY, bus writes to regs 0-7 and to CTRL.START are ignored; W1C writes to STATUS still apply.
- CTRL write with bit0=0 while BUSY: abort. AES_START=0, go to IDLE, DONE stays 0, MSG_DEC unchanged.
- A read of MSG_DEC in the same cycle as CAPTURE returns the old value. The new value is readable from the next read.
- Simultaneous W1C of DONE and the CAPTURE set of DONE in the same cycle: the hardware set wins.
- AES_KEY, AES_MSG_ENC and EXPORT_DATA are continuous combinational views of the registers.

Decomposition:
- Package aes_if_pkg:
  - Address constants ADDR_KEY0=0, ADDR_MSG0=4, ADDR_DEC0=8, ADDR_CTRL=14, ADDR_STATUS=15.
  - Status bit indices.
  - State enum aes_if_state_t {IDLE, LAUNCH, BUSY, CAPTURE}.
- One sub-module is natural: aes_if_regfile, the 16x32 byte-enabled register file with its read mux. The FSM and watchdog stay in the top.

Test Plan:
- FIPS-197 run: write KEY 00010203,04050607,08090a0b,0c0d0e0f and MSG 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, then write CTRL=1.
  - With a real core, poll STATUS until DONE=1.
  - Required: regs 8-11 = 00112233,44556677,8899aabb,ccddeeff; STATUS=1.
- Byte enables: write reg0=AABBCCDD with BYTE_EN=0101 over 00000000. Required: reg0 reads 00BB00DD; EXPORT_DATA=00BB_xxxx, where xxxx = reg3[15:0].
- Busy lockout: with the core stub holding AES_DONE=0, launch and then write reg0=FFFFFFFF. Required: reg0 unchanged, STATUS reads 2, AES_START=1.
- Timeout: stub never asserts done, TIMEOUT_CYCLES=16. Required: AES_START falls exactly 17 cycles after the CTRL write; STATUS reads 4; writing STATUS=4 then reads 0.
- Abort and reset: launch, then write CTRL=0. Required: AES_START=0 next cycle, DONE=0. Relaunch, then assert RESET mid-BUSY: required AES_START=0 immediately (async), all registers read 0.
- Read latency and collision: read STATUS in the CAPTURE cycle. Required: the data returned one cycle later reads 2 (BUSY); the following read returns 1.
